// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// State encoding, parity modes and default oversampling ratio.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int OS_DEFAULT = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both stages reset to RST_VAL so an idle-high line stays idle.
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 16x oversampled start/data/parity/stop
// with a one-entry output register and error reporting.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int DBIT    = 16,
    parameter int SB_TICK = 16,
    parameter int PARITY  = PAR_NONE,
    parameter int OS      = OS_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    input  logic            rd_ack,
    output logic [DBIT-1:0] dout,
    output logic            rx_valid,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err,
    output logic            overrun
);

    localparam int SW = $clog2(OS * 2);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_HALF = SW'(OS / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    rx_state_e       state, state_n;
    logic [SW-1:0]   s, s_n;
    logic [NW-1:0]   n, n_n;
    logic [DBIT-1:0] shreg, shreg_n;
    logic            perr_q, perr_n;
    logic            rx_s;
    logic            done;
    logic            ferr;

    uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            s      <= '0;
            n      <= '0;
            shreg  <= '0;
            perr_q <= 1'b0;
        end else begin
            state  <= state_n;
            s      <= s_n;
            n      <= n_n;
            shreg  <= shreg_n;
            perr_q <= perr_n;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        shreg_n = shreg;
        perr_n  = perr_q;
        done    = 1'b0;
        ferr    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_n = ST_START;
                    s_n     = '0;
                    perr_n  = 1'b0;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s == S_HALF) begin
                        // A start bit that is high again at its middle is noise.
                        state_n = rx_s ? ST_IDLE : ST_DATA;
                        s_n     = '0;
                        n_n     = '0;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s == S_BIT) begin
                        shreg_n = {rx_s, shreg[DBIT-1:1]};
                        s_n     = '0;
                        if (n == N_LAST) begin
                            state_n = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                        end else begin
                            n_n = n + 1'b1;
                        end
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            ST_PAR: begin
                if (s_tick) begin
                    if (s == S_BIT) begin
                        if (PARITY == PAR_ODD) begin
                            perr_n = ~((^shreg) ^ rx_s);
                        end else begin
                            perr_n = (^shreg) ^ rx_s;
                        end
                        state_n = ST_STOP;
                        s_n     = '0;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (s == S_STOP) begin
                        ferr    = ~rx_s;
                        done    = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout         <= '0;
            rx_valid     <= 1'b0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            parity_err   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            rx_done_tick <= done;
            if (done) begin
                // A held, unread word wins; the new one is dropped.
                if (!rx_valid || rd_ack) begin
                    dout       <= shreg;
                    frame_err  <= ferr;
                    parity_err <= perr_q;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rd_ack && rx_valid) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench: three deframers (no, even, odd parity)
// share one line; table vectors, corner sequences and random frames.
module tb_uart_rx_deframer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        s_tick = 1'b0;
    logic        rx = 1'b1;
    int          sel = 0;
    logic [2:0]  rx_d;
    logic [2:0]  ack = '0;
    logic [15:0] dout [3];
    logic [2:0]  valid, done, fe, pe, ov;
    int          done_cnt [3] = '{0, 0, 0};

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign rx_d[g] = (sel == g) ? rx : 1'b1;
        uart_rx_deframer #(
            .DBIT(16), .SB_TICK(16), .PARITY(g), .OS(16)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .s_tick       (s_tick),
            .rx           (rx_d[g]),
            .rd_ack       (ack[g]),
            .dout         (dout[g]),
            .rx_valid     (valid[g]),
            .rx_done_tick (done[g]),
            .frame_err    (fe[g]),
            .parity_err   (pe[g]),
            .overrun      (ov[g])
        );
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done[i]) done_cnt[i] = done_cnt[i] + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick_n(input int cnt);
        repeat (cnt) begin
            repeat (3) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b, input int cnt);
        rx = b;
        tick_n(cnt);
    endtask

    task automatic send_frame(input int k, input logic [15:0] d,
                              input logic pbit, input logic stop_ok);
        sel = k;
        send_bit(1'b0, 16);
        for (int i = 0; i < 16; i++) send_bit(d[i], 16);
        if (k != 0) send_bit(pbit, 16);
        if (stop_ok) begin
            send_bit(1'b1, 16);
        end else begin
            send_bit(1'b0, 12);
            send_bit(1'b1, 4);
        end
        send_bit(1'b1, 8);
    endtask

    task automatic do_ack(input int k);
        @(negedge clk);
        ack[k] = 1'b1;
        @(negedge clk);
        ack[k] = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        int          k;
        logic [15:0] data;
        logic        pbit;
        logic        stop_ok;
        logic        ferr;
        logic        perr;
    } vec_t;

    // Reference consumer-side view of each receiver.
    logic        m_valid [3];
    logic [15:0] m_dout [3];
    logic        m_ferr [3];
    logic        m_perr [3];
    logic        m_ovr [3];

    function automatic logic exp_perr(input int k, input logic [15:0] d,
                                      input logic p);
        logic ones_odd;
        ones_odd = ($countones(d) % 2) == 1;
        if (k == 0) return 1'b0;
        if (k == 1) return ones_odd ^ p;
        return ~(ones_odd ^ p);
    endfunction

    initial begin
        vec_t tbl [7];
        int   base;

        tbl[0] = '{0, 16'hA55A, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{0, 16'h00FF, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{0, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1, 16'h0003, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{2, 16'h0003, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{2, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_dout", dout[0], 0);
        chk("rst_valid", valid, 0);
        reset = 1'b1;
        tick_n(4);
        chk("rst_valid_after", valid, 0);
        chk("rst_flags", {fe, pe, ov}, 0);
        chk("rst_done", done_cnt[0] + done_cnt[1] + done_cnt[2], 0);

        foreach (tbl[i]) begin
            base = done_cnt[tbl[i].k];
            send_frame(tbl[i].k, tbl[i].data, tbl[i].pbit, tbl[i].stop_ok);
            chk($sformatf("tbl%0d_done", i), done_cnt[tbl[i].k] - base, 1);
            chk($sformatf("tbl%0d_valid", i), valid[tbl[i].k], 1);
            chk($sformatf("tbl%0d_dout", i), dout[tbl[i].k], tbl[i].data);
            chk($sformatf("tbl%0d_ferr", i), fe[tbl[i].k], tbl[i].ferr);
            chk($sformatf("tbl%0d_perr", i), pe[tbl[i].k], tbl[i].perr);
            do_ack(tbl[i].k);
            chk($sformatf("tbl%0d_ack", i), valid[tbl[i].k], 0);
        end

        // Short low pulse on the line must be rejected as a glitch.
        sel = 0;
        base = done_cnt[0];
        send_bit(1'b0, 5);
        send_bit(1'b1, 20);
        chk("glitch_done", done_cnt[0] - base, 0);
        chk("glitch_valid", valid[0], 0);

        // Second word arriving while the first is unread.
        base = done_cnt[0];
        send_frame(0, 16'h1234, 1'b0, 1'b1);
        send_frame(0, 16'hBEEF, 1'b0, 1'b1);
        chk("ovr_done", done_cnt[0] - base, 2);
        chk("ovr_dout", dout[0], 16'h1234);
        chk("ovr_flag", ov[0], 1);
        chk("ovr_valid", valid[0], 1);
        do_ack(0);
        chk("ovr_ack_valid", valid[0], 0);
        chk("ovr_ack_flag", ov[0], 0);

        for (int k = 0; k < 3; k++) begin
            m_valid[k] = valid[k] ? 1'b1 : 1'b0;
            m_valid[k] = 1'b0;
            m_dout[k]  = 16'h0;
            m_ferr[k]  = 1'b0;
            m_perr[k]  = 1'b0;
            m_ovr[k]   = 1'b0;
        end

        for (int it = 0; it < 16; it++) begin
            int          k;
            logic [15:0] d;
            logic        p, sok;
            k   = int'($urandom_range(0, 2));
            d   = 16'($urandom);
            p   = 1'($urandom_range(0, 1));
            sok = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 1) == 1) begin
                do_ack(k);
                if (m_valid[k]) begin
                    m_valid[k] = 1'b0;
                    m_ovr[k]   = 1'b0;
                end
            end
            base = done_cnt[k];
            send_frame(k, d, p, sok);
            if (!m_valid[k]) begin
                m_valid[k] = 1'b1;
                m_dout[k]  = d;
                m_ferr[k]  = ~sok;
                m_perr[k]  = exp_perr(k, d, p);
            end else begin
                m_ovr[k] = 1'b1;
            end
            chk($sformatf("rnd%0d_done", it), done_cnt[k] - base, 1);
            chk($sformatf("rnd%0d_valid", it), valid[k], m_valid[k]);
            chk($sformatf("rnd%0d_dout", it), dout[k], m_dout[k]);
            chk($sformatf("rnd%0d_ferr", it), fe[k], m_ferr[k]);
            chk($sformatf("rnd%0d_perr", it), pe[k], m_perr[k]);
            chk($sformatf("rnd%0d_ovr", it), ov[k], m_ovr[k]);
        end

        // Reset in the middle of data bit 7 of an all-ones word.
        do_ack(0);
        send_frame(0, 16'h00F0, 1'b0, 1'b1);
        chk("pre_rst_valid", valid[0], 1);
        sel = 0;
        send_bit(1'b0, 16);
        for (int i = 0; i < 7; i++) send_bit(1'b1, 16);
        send_bit(1'b1, 8);
        base = done_cnt[0];
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_dout", dout[0], 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_flags", {fe, pe, ov}, 0);
        @(negedge clk);
        reset = 1'b1;
        send_bit(1'b1, 16 * 9 + 8);
        chk("post_rst_done", done_cnt[0] - base, 0);
        chk("post_rst_valid", valid[0], 0);
        send_frame(0, 16'h5555, 1'b0, 1'b1);
        chk("post_rst_word_done", done_cnt[0] - base, 1);
        chk("post_rst_word", dout[0], 16'h5555);
        chk("post_rst_word_ferr", fe[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
